fifo_frame_reader: RTL and testbench

Read-side controller for the team's `synchronous_FIFO`. It drains length-prefixed frames from the FIFO's `rd_en`/`dout`/`empty` port and presents the payload bytes on a valid/ready stream with a `last` marker. It sits between a FIFO filled by an upstream writer and any downstream consumer that applies backpressure. It sustains one byte per cycle despite the FIFO's one-cycle read latency.

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_frame_reader_skid_buf2.sv | 67 ++++++
 rtl/fifo_frame_reader.sv | 126 ++++++++++++
 tb/tb_fifo_frame_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO frame reader.
// Contents: the reader FSM state enum and the default byte and counter widths.
// Import this package wherever the frame reader types are needed.
package fifo_reader_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        PAY  = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_frame_reader_skid_buf2.sv
// skid_buf2: two-entry register buffer with a push-only write port and a valid/ready read port.
// Latency: a write appears at the read port on the next cycle; the read port is registered.
// Backpressure: none on the write side; the writer must keep occupancy at or below 2.
// Ports: wr_en_i/wr_dat_i (push), rd_vld_o/rd_rdy_i/rd_dat_o (pop), occ_o (0..2 entries).
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_dat_i,
    output logic         rd_vld_o,
    input  logic         rd_rdy_i,
    output logic [W-1:0] rd_dat_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   occ_q, occ_d;
    logic         rd_fire;

    assign rd_vld_o = (occ_q != 2'd0);
    assign rd_dat_o = slot0_q;
    assign occ_o    = occ_q;
    assign rd_fire  = rd_vld_o && rd_rdy_i;

    // slot0 is always the head; slot1 only ever holds the entry behind it.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        unique case ({wr_en_i, rd_fire})
            2'b10: begin
                if (occ_q == 2'd0) slot0_d = wr_dat_i;
                else               slot1_d = wr_dat_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    slot0_d = wr_dat_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = wr_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains length-prefixed frames from a 1-cycle-latency FIFO onto a valid/ready byte stream.
// Latency: length pop at T, first payload byte valid at T+4, then one byte per cycle.
// Backpressure: pops are credit-limited so at most 2 bytes sit beyond the consumer; m_data/m_last hold under stall.
// Ports: fifo_empty/fifo_rd_en/fifo_dout (FIFO read side), m_valid/m_ready/m_data/m_last (stream),
//        zero_len (empty-frame pulse), busy (frame in progress), frames_done (wrapping frame count).
module fifo_frame_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  zero_len,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_done
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] req_left_q, req_left_d;
    logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
    logic [CNT_WIDTH-1:0]  frames_done_q, frames_done_d;
    logic                  zero_len_q, zero_len_d;
    logic                  inflight_q;
    logic                  rd_en;
    logic                  buf_wr_en;
    logic [1:0]            buf_occ;
    logic                  hs;
    logic                  credit;

    // Data popped in IDLE lands during LEN and is the length, not payload,
    // so only pops issued in PAY feed the output buffer.
    assign buf_wr_en = inflight_q && (state_q == PAY);

    skid_buf2 #(.W(DATA_WIDTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (buf_wr_en),
        .wr_dat_i (fifo_dout),
        .rd_vld_o (m_valid),
        .rd_rdy_i (m_ready),
        .rd_dat_o (m_data),
        .occ_o    (buf_occ)
    );

    assign hs     = m_valid && m_ready;
    assign m_last = m_valid && (out_left_q == DATA_WIDTH'(1));

    // Buffer entries plus the byte still in the FIFO pipeline never exceed 2:
    // a pop is allowed when there is room, or when a byte leaves this cycle.
    assign credit = ((3'({1'b0, buf_occ}) + 3'({2'b00, inflight_q})) < 3'd2) || hs;

    always_comb begin
        state_d       = state_q;
        req_left_d    = req_left_q;
        out_left_d    = out_left_q;
        frames_done_d = frames_done_q;
        zero_len_d    = 1'b0;
        rd_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = LEN;
                end
            end
            LEN: begin
                req_left_d = fifo_dout;
                out_left_d = fifo_dout;
                if (fifo_dout == '0) begin
                    zero_len_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = PAY;
                end
            end
            PAY: begin
                if (!fifo_empty && (req_left_q != '0) && credit) begin
                    rd_en      = 1'b1;
                    req_left_d = req_left_q - DATA_WIDTH'(1);
                end
                if (hs) begin
                    out_left_d = out_left_q - DATA_WIDTH'(1);
                    if (m_last) begin
                        frames_done_d = frames_done_q + CNT_WIDTH'(1);
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop request is combinational; gate it so it drops with reset at once.
    assign fifo_rd_en = rd_en && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_left_q    <= '0;
            out_left_q    <= '0;
            frames_done_q <= '0;
            zero_len_q    <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_left_q    <= req_left_d;
            out_left_q    <= out_left_d;
            frames_done_q <= frames_done_d;
            zero_len_q    <= zero_len_d;
            inflight_q    <= fifo_rd_en;
        end
    end

    assign zero_len    = zero_len_q;
    assign busy        = (state_q != IDLE);
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          zero_len;
    logic          busy;
    logic [CW-1:0] frames_done;

    fifo_frame_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .zero_len    (zero_len),
        .busy        (busy),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous FIFO: data appears the cycle after the pop.
    logic [7:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] frm[$];
    int checks = 0;
    int passes = 0;
    int exp_zl = 0;
    int zl_seen = 0;
    int hs_cnt = 0;
    int exp_done = 0;
    bit pend_fd = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    endtask

    // Monitor: pops the model's expectation for every accepted byte.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            exp_done   = 0;
            pend_fd    = 0;
            prev_stall = 0;
        end else begin
            if (pend_fd) begin
                chk("frames_done", int'(frames_done), exp_done);
                pend_fd = 0;
            end
            if (fifo_rd_en) chk("pop_while_empty", int'(fifo_empty), 0);
            chk("occ_le_2", int'(dut.buf_occ <= 2'd2), 1);
            if (prev_stall)
                chk("stall_hold", int'({m_valid, m_data, m_last}), int'({1'b1, prev_d, prev_l}));
            if (zero_len) zl_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(m_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", int'(m_data), int'(e.d));
                    chk("last", int'(m_last), int'(e.l));
                    if (e.l) begin
                        exp_done = (exp_done + 1) % (1 << CW);
                        pend_fd  = 1;
                    end
                end
                hs_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Reference model: a frame of N bytes yields N outputs, last on the Nth;
    // an empty frame yields no output and one zero_len pulse.
    task automatic model_frame();
        exp_t e;
        if (frm.size() == 0) exp_zl++;
        for (int i = 0; i < frm.size(); i++) begin
            e.d = frm[i];
            e.l = (i == frm.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic add_frame(input int npush);
        model_frame();
        push(8'(frm.size()));
        for (int i = 0; i < npush; i++) push(frm[i]);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) tick();
        chk(nm, int'(exp_q.size() == 0 && !busy), 1);
        tick();
        chk("fifo_consumed", rd_ptr, wr_ptr);
        chk("zero_len_count", zl_seen, exp_zl);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        chk(nm, int'(m_valid), 1);
    endtask

    initial begin
        int t_pop, t_v, start, base;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_pop, t_v, start, base;
        logic [7:0] pend[$];

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", int'({fifo_rd_en, m_valid, m_data, m_last, zero_len, busy, frames_done}), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_pop", rd_ptr, 0);

        // Frame 03 AA 4B 3B, free-flowing
        m_ready = 1'b1;
        frm = '{8'hAA, 8'h4B, 8'h3B};
        start = rd_ptr;
        add_frame(3);
        t_pop = cyc;
        wait_valid("s1_valid");
        t_v = cyc;
        chk("first_valid_latency", t_v - t_pop, 4);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("frame_cycles", cyc - t_pop, 3 + 4);
        chk("s1_pops", rd_ptr - start, 4);
        drain("s1_drain");

        // Same frame with 6 cycles of stall
        m_ready = 1'b0;
        start = rd_ptr;
        add_frame(3);
        wait_valid("s2_valid");
        repeat (5) tick();
        chk("stall_pops", rd_ptr - start, 3);
        chk("stall_head", int'(m_data), 8'hAA);
        m_ready = 1'b1;
        drain("s2_drain");

        // Zero-length frame then 23 FE
        frm = {};
        add_frame(0);
        frm = '{8'h23, 8'hFE};
        add_frame(2);
        drain("s3_drain");

        // Frame of 5 with only 2 payload bytes available at first
        frm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        add_frame(2);
        repeat (10) tick();
        chk("underrun_valid_low", int'(m_valid), 0);
        chk("underrun_busy", int'(busy), 1);
        for (int i = 2; i < 5; i++) push(frm[i]);
        drain("s4_drain");

        // Reset mid-frame after 2 of 5 bytes
        frm = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        base = hs_cnt;
        add_frame(2);
        for (int i = 0; i < 100 && hs_cnt < base + 2; i++) tick();
        chk("pre_reset_bytes", hs_cnt - base, 2);
        tick();
        rst_n = 1'b0;
        push(8'h01);
        push(8'h5A);
        #1;
        chk("midrun_reset_outputs", int'({fifo_rd_en, m_valid, m_data, m_last, zero_len, busy, frames_done}), 0);
        repeat (2) tick();
        chk("reset_no_pop", rd_ptr, wr_ptr - 2);
        rst_n = 1'b1;
        chk("post_reset_busy", int'(busy), 0);
        frm = '{8'h5A};
        model_frame();
        drain("s5_drain");

        // Randomized frames, gaps and backpressure
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(0, 12);
            frm = {};
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
            model_frame();
            pend.push_back(8'(len));
            for (int i = 0; i < len; i++) pend.push_back(frm[i]);
        end
        while (pend.size() != 0) begin
            m_ready = ($urandom % 4) != 0;
            if (($urandom % 3) != 0) push(pend.pop_front());
            tick();
        end
        m_ready = 1'b1;
        drain("rand_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
